// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
//   state_t    : controller FSM states; the encoding is visible on state_o
//   REG_ZERO   : RV32 hard-wired zero register index
//   WCNT_W     : width of the memory wait counter (covers timeouts up to 65535)
package hazard_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned WCNT_W   = 16;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for hazard_stall_ctrl.
//   master : pipeline (ID/EX/MEM) side, drives hazard sources, receives controls
//   slave  : controller side
// Optional macro HAZARD_PERF_EN adds perf_stall_cnt/perf_flush_cnt/perf_wait_cnt.
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_AW = 5
`ifdef HAZARD_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) ();

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              mem_ready;

  logic              stall;
  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_flush;
  logic              idex_hold;
  logic              exmem_hold;
  logic              memwb_hold;
  logic              err;
  logic [1:0]        state_o;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  perf_stall_cnt;
  logic [CNT_W-1:0]  perf_flush_cnt;
  logic [CNT_W-1:0]  perf_wait_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_req, mem_ready,
    input  stall, pc_we, ifid_we, ifid_flush, idex_flush, idex_hold,
           exmem_hold, memwb_hold, err, state_o,
           perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_req, mem_ready,
    output stall, pc_we, ifid_we, ifid_flush, idex_flush, idex_hold,
           exmem_hold, memwb_hold, err, state_o,
           perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
  );
`else
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_req, mem_ready,
    input  stall, pc_we, ifid_we, ifid_flush, idex_flush, idex_hold,
           exmem_hold, memwb_hold, err, state_o
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_req, mem_ready,
    output stall, pc_we, ifid_we, ifid_flush, idex_flush, idex_hold,
           exmem_hold, memwb_hold, err, state_o
  );
`endif

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a dependency).
//   id_rs1/id_rs2/id_uses_rs2 : source operands of the ID instruction
//   ex_rd/ex_memread          : destination and load flag of the EX instruction
//   load_use_c                : hazard present this cycle
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  output logic              load_use_c
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_nonzero = (ex_rd != REG_AW'(REG_ZERO));
  assign rs1_hit    = (ex_rd == id_rs1);
  assign rs2_hit    = id_uses_rs2 & (ex_rd == id_rs2);
  assign load_use_c = ex_memread & rd_nonzero & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage RV32 core.
// Sequences PC/IF-ID enables, IF-ID/ID-EX flushes and the downstream register
// holds for load-use bubbles, taken-branch flushes and data-memory wait states.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : hazard sources in, pipeline controls out, state_o/err status
// All control outputs are decoded combinationally from the registered state
// and the current inputs. Optional macro HAZARD_PERF_EN adds event counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned WAIT_TIMEOUT = 255
`ifdef HAZARD_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.slave  bus
);

  localparam logic [WCNT_W-1:0] TIMEOUT = WCNT_W'(WAIT_TIMEOUT);

  state_t            state, state_nx;
  logic [WCNT_W-1:0] wait_cnt, wait_nx;
  logic              load_use;
  logic              mem_busy;
  logic              freeze;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs2 (bus.id_uses_rs2),
    .ex_rd       (bus.ex_rd),
    .ex_memread  (bus.ex_memread),
    .load_use_c  (load_use)
  );

  assign mem_busy    = bus.mem_req & ~bus.mem_ready;
  assign bus.state_o = state;

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  // Next-state and control decode; reset forces the RUN idle controls
  always_comb begin
    state_nx       = state;
    wait_nx        = wait_cnt;
    freeze         = 1'b0;
    bus.stall      = 1'b0;
    bus.pc_we      = 1'b1;
    bus.ifid_we    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    bus.err        = 1'b0;

    if (rst_n) begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            freeze   = 1'b1;
            state_nx = MEM_WAIT;
            wait_nx  = WCNT_W'(1);
          end else if (bus.ex_branch_taken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
          end else if (load_use) begin
            bus.stall   = 1'b1;
            bus.pc_we   = 1'b0;
            bus.ifid_we = 1'b0;
          end
        end
        MEM_WAIT: begin
          // Branch/load-use stay frozen here and are re-evaluated back in RUN
          if (bus.mem_ready) begin
            state_nx = RUN;
            wait_nx  = '0;
          end else begin
            freeze = 1'b1;
            if (wait_cnt == TIMEOUT) begin
              state_nx = ERROR;
            end else if (wait_cnt < TIMEOUT) begin
              wait_nx = wait_cnt + WCNT_W'(1);
            end
          end
        end
        ERROR: begin
          freeze  = 1'b1;
          bus.err = 1'b1;
        end
        default: begin
          freeze   = 1'b1;
          state_nx = ERROR;
        end
      endcase
    end

    if (freeze) begin
      bus.pc_we   = 1'b0;
      bus.ifid_we = 1'b0;
    end
    bus.idex_hold  = freeze;
    bus.exmem_hold = freeze;
    bus.memwb_hold = freeze;
  end

`ifdef HAZARD_PERF_EN
  // Event counters; no events are decoded in ERROR, so they freeze there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.perf_stall_cnt <= '0;
      bus.perf_flush_cnt <= '0;
      bus.perf_wait_cnt  <= '0;
    end else begin
      if (bus.stall)          bus.perf_stall_cnt <= bus.perf_stall_cnt + CNT_W'(1);
      if (bus.ifid_flush)     bus.perf_flush_cnt <= bus.perf_flush_cnt + CNT_W'(1);
      if (state == MEM_WAIT)  bus.perf_wait_cnt  <= bus.perf_wait_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_hazard_stall_ctrl;

  localparam int unsigned TO = 4;

  // Expected control vectors: {stall,pc_we,ifid_we,ifid_flush,idex_flush,
  //                            idex_hold,exmem_hold,memwb_hold,err}
  localparam logic [8:0] V_IDLE  = 9'b0_1_1_0_0_0_0_0_0;
  localparam logic [8:0] V_FRZ   = 9'b0_0_0_0_0_1_1_1_0;
  localparam logic [8:0] V_FLUSH = 9'b0_1_1_1_1_0_0_0_0;
  localparam logic [8:0] V_STALL = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_ERR   = 9'b0_0_0_0_0_1_1_1_1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model: mode 0=running, 1=waiting on memory, 2=dead
  int   m_mode;
  int   m_waited;
  logic [31:0] m_pstall, m_pflush, m_pwait;

  hazard_stall_ctrl_if #(.REG_AW(5)) bus ();

  hazard_stall_ctrl #(.REG_AW(5), .WAIT_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int rs1, input int rs2, input bit u2, input int rd,
                       input bit mrd, input bit br, input bit req, input bit rdy);
    bus.id_rs1          = 5'(rs1);
    bus.id_rs2          = 5'(rs2);
    bus.id_uses_rs2     = u2;
    bus.ex_rd           = 5'(rd);
    bus.ex_memread      = mrd;
    bus.ex_branch_taken = br;
    bus.mem_req         = req;
    bus.mem_ready       = rdy;
  endtask

  function automatic bit dep();
    int rd;
    rd = int'(bus.ex_rd);
    return bus.ex_memread && rd != 0 &&
           (rd == int'(bus.id_rs1) || (bus.id_uses_rs2 && rd == int'(bus.id_rs2)));
  endfunction

  function automatic logic [8:0] expect_ctrl();
    bit busy;
    busy = bus.mem_req && !bus.mem_ready;
    if (!rst_n)       return V_IDLE;
    if (m_mode == 2)  return V_ERR;
    if (m_mode == 1)  return bus.mem_ready ? V_IDLE : V_FRZ;
    if (busy)                 return V_FRZ;
    if (bus.ex_branch_taken)  return V_FLUSH;
    if (dep())                return V_STALL;
    return V_IDLE;
  endfunction

  function automatic logic [8:0] dut_ctrl();
    return {bus.stall, bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_flush,
            bus.idex_hold, bus.exmem_hold, bus.memwb_hold, bus.err};
  endfunction

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_tick();
    bit busy;
    busy = bus.mem_req && !bus.mem_ready;
    if (m_mode == 0) begin
      if (busy) begin
        m_mode   = 1;
        m_waited = 1;
      end else if (bus.ex_branch_taken) begin
        m_pflush++;
      end else if (dep()) begin
        m_pstall++;
      end
    end else if (m_mode == 1) begin
      m_pwait++;
      if (bus.mem_ready) begin
        m_mode   = 0;
        m_waited = 0;
      end else if (m_waited >= int'(TO)) begin
        m_mode = 2;
      end else begin
        m_waited++;
      end
    end
  endtask

  // Called at a falling edge with inputs already applied
  task automatic step(input string tag);
    if (!rst_n) begin
      m_mode = 0; m_waited = 0;
      m_pstall = 0; m_pflush = 0; m_pwait = 0;
    end
    #1;
    check({tag, " ctrl"},  32'(dut_ctrl()),     32'(expect_ctrl()));
    check({tag, " state"}, 32'(bus.state_o),    32'(m_mode));
`ifdef HAZARD_PERF_EN
    check({tag, " pstall"}, bus.perf_stall_cnt, m_pstall);
    check({tag, " pflush"}, bus.perf_flush_cnt, m_pflush);
    check({tag, " pwait"},  bus.perf_wait_cnt,  m_pwait);
`endif
    @(posedge clk);
    if (rst_n) model_tick();
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    m_mode = 0; m_waited = 0;
    m_pstall = 0; m_pflush = 0; m_pwait = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step("reset_idle");
    // Hazards present during reset must not leak through
    drive(5, 0, 0, 5, 1, 1, 1, 0);
    step("reset_masked");
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("run_idle");

    // Load-use: one bubble, then EX holds the bubble
    drive(5, 0, 0, 5, 1, 0, 0, 0); step("lu_rs1");
    drive(5, 0, 0, 0, 0, 0, 0, 0); step("lu_cleared");
    drive(5, 0, 0, 0, 1, 0, 0, 0); step("lu_x0");
    drive(1, 7, 1, 7, 1, 0, 0, 0); step("lu_rs2");
    drive(1, 7, 0, 7, 1, 0, 0, 0); step("lu_rs2_unused");

    // Taken branch flush
    drive(0, 0, 0, 0, 0, 1, 0, 0); step("branch");
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("branch_after");

    // Memory wait of 4 cycles, then ready
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("mem_wait");
    drive(0, 0, 0, 0, 0, 0, 1, 1); step("mem_ready");
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("mem_done");
    drive(0, 0, 0, 0, 0, 0, 1, 1); step("zero_wait");

    // Simultaneous busy + branch + load-use: freeze, then flush after ready
    drive(5, 0, 0, 5, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) step("combo_frz");
    drive(5, 0, 0, 5, 1, 1, 1, 1); step("combo_rdy");
    drive(5, 0, 0, 5, 1, 1, 0, 0); step("combo_flush");
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("combo_done");

    // Reset in the middle of a wait
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("pre_rst_wait");
    rst_n = 1'b0; step("rst_mid_wait");
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("post_rst");

    // Timeout into sticky ERROR (also proves the wait counter restarted)
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < int'(TO) + 3; i++) step("timeout");
    drive(5, 0, 0, 5, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) step("err_sticky");
    rst_n = 1'b0; step("err_reset");
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("err_cleared");

    // Randomized traffic with occasional recovery resets
    for (int n = 0; n < 600; n++) begin
      rst_n = (m_mode == 2 && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 6));
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV32 core. It detects load-use hazards, taken-branch flushes and data-memory wait states, and sequences the pipeline-register enables/flushes. It also drives the `stall` input of the ID-stage control unit, which neutralises all control signals when stall=1, so that it injects a bubble. It sits beside the ID stage and takes inputs from ID, EX and MEM.

Parameters:
- REG_AW, 5, register-address width.
- WAIT_TIMEOUT, 255, max consecutive MEM_WAIT cycles before ERROR; legal range 1..65535.
- CNT_W, 32, width of perf counters (used only with HAZARD_PERF_EN).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  REG_AW  rs1 of instruction in ID.
- id_rs2  in  REG_AW  rs2 of instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch).
- ex_rd  in  REG_AW  destination register of instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage holds a load/store.
- mem_ready  in  1  data memory completes the access this cycle.
- stall  out  1  to control unit; forces a bubble into ID/EX.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_flush  out  1  clear ID/EX to NOP.
- idex_hold, exmem_hold, memwb_hold  out  1 each  freeze the respective register.
- err  out  1  sticky memory-timeout error.
- state_o  out  2  current FSM state (RUN=0, MEM_WAIT=1, ERROR=2).

Behaviour:
- Reset (async, rst_n=0): state=RUN, wait_cnt=0, err=0. While reset is asserted, outputs hold the RUN idle values: pc_we=1, ifid_we=1, all other outputs 0.
- All outputs are combinational from the registered state and the current inputs. State and counters update on the rising edge of clk.
- load_use = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- mem_busy = mem_req & ~mem_ready.
- RUN priority is mem_busy > ex_branch_taken > load_use:
  - mem_busy: pc_we=0, ifid_we=0, idex_hold=exmem_hold=memwb_hold=1, stall=0; next state MEM_WAIT, wait_cnt<=1.
  - ex_branch_taken: pc_we=1 (target), ifid_flush=1, idex_flush=1, stall=0; stay in RUN.
  - load_use: stall=1, pc_we=0, ifid_we=0; stay in RUN. This is a single bubble; it clears naturally the next cycle.
  - none: pc_we=1, ifid_we=1, all else 0.
- MEM_WAIT: all holds asserted as in the mem_busy case. A branch or load-use condition in EX/ID is frozen and is not acted on.
  - mem_ready=1: holds released that same cycle; next state RUN, wait_cnt<=0. The frozen branch/load-use is then evaluated in the next RUN cycle.
  - else if wait_cnt==WAIT_TIMEOUT: next state ERROR.
  - else wait_cnt<=wait_cnt+1, saturating at WAIT_TIMEOUT.
- ERROR: err=1; all holds asserted, pc_we=0, ifid_we=0; no exit except reset.
- mem_req=1 with mem_ready=1 in RUN means a zero-wait access; no state change.
- Illegal state encoding (3): next state ERROR.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - adds outputs perf_stall_cnt, perf_flush_cnt, perf_wait_cnt, each CNT_W bits, reset to 0.
  - perf_stall_cnt increments on each load-use bubble, perf_flush_cnt on each taken-branch flush, perf_wait_cnt on each MEM_WAIT cycle.
  - all three wrap modulo 2^CNT_W and are frozen in ERROR.
- When not defined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds the state enum (RUN, MEM_WAIT, ERROR) and the RV32 register-zero constant.
- One sub-module, hazard_detect: purely combinational load_use comparator. The FSM, counters and output decode stay in hazard_stall_ctrl.

Test Plan:
1. Reset mid-MEM_WAIT (rst_n low after 3 wait cycles) -> state_o=0 and all holds=0 immediately; wait_cnt=0 after release.
2. Load-use: ex_memread=1, ex_rd=5, id_rs1=5 -> exactly one cycle of stall=1, pc_we=0, ifid_we=0. The same stimulus with ex_rd=0 -> no stall.
3. Taken branch: ex_branch_taken=1, no other hazard -> ifid_flush=idex_flush=1 and pc_we=1 for one cycle; state stays RUN.
4. Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> holds asserted for 4 cycles, released on the ready cycle, state_o returns to 0.
5. Simultaneous mem_busy, ex_branch_taken and load_use -> freeze only. After mem_ready, the flush fires in the next cycle.
6. Timeout: WAIT_TIMEOUT=4, mem_ready held 0 -> state_o=2 and err=1 after 4 wait cycles, sticky until rst_n=0.
